// File: rtl/sc_phase_gen_pkg.sv
// Shared types and helpers for the two-phase non-overlapping clock generator.
package sc_phase_pkg;

  localparam int unsigned MIN_LEN = 1;

  // Bit positions of the one-hot state register; phi1/phi2/busy tap these directly.
  localparam int ST_IDLE_B   = 0;
  localparam int ST_PHI1_B   = 1;
  localparam int ST_DEAD12_B = 2;
  localparam int ST_PHI2_B   = 3;
  localparam int ST_DEAD21_B = 4;

  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_PHI1   = 5'b00010,
    ST_DEAD12 = 5'b00100,
    ST_PHI2   = 5'b01000,
    ST_DEAD21 = 5'b10000
  } state_e;

  // A programmed length of zero behaves as one cycle, so dead time never vanishes.
  function automatic int unsigned max1(input int unsigned len);
    return (len < MIN_LEN) ? MIN_LEN : len;
  endfunction

endpackage

// File: rtl/sc_phase_gen_if.sv
// Configuration and phase-output bundle between the controller and the SC filter side.
interface sc_phase_gen_if #(
  parameter int CNT_W   = 8,
  parameter int FRAME_W = 16
);
  logic               en;
  logic [CNT_W-1:0]   phi1_len;
  logic [CNT_W-1:0]   phi2_len;
  logic [CNT_W-1:0]   dead_len;
  logic               phi1;
  logic               phi2;
  logic               sample_stb;
  logic               busy;
  logic [FRAME_W-1:0] frame_cnt;

  modport master (
    output en, phi1_len, phi2_len, dead_len,
    input  phi1, phi2, sample_stb, busy, frame_cnt
  );

  modport slave (
    input  en, phi1_len, phi2_len, dead_len,
    output phi1, phi2, sample_stb, busy, frame_cnt
  );
endinterface

// File: rtl/sc_phase_timer.sv
// Loadable down-counter timing the current phase; done marks the last cycle of it.
module sc_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             done
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Load takes priority; otherwise count down and park at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = value;
    end else if (count_q != '0) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/sc_phase_gen.sv
// Non-overlapping phi1/phi2 sequencer for the switched-capacitor filter switches.
//
//   state  | meaning
//   IDLE   | stopped, both phases low, waiting for en
//   PHI1   | phi1 high for the latched phi1 length
//   DEAD12 | both low, gap between phi1 fall and phi2 rise
//   PHI2   | phi2 high; sample_stb on its last cycle
//   DEAD21 | both low, gap before the next frame; frame ends here
module sc_phase_gen
  import sc_phase_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int FRAME_W = 16
) (
  input logic          clk,
  input logic          rst_n,
  sc_phase_gen_if.slave bus
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   n2_q, n2_d;
  logic [CNT_W-1:0]   nd_q, nd_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
  logic               tmr_load;
  logic [CNT_W-1:0]   tmr_value;
  logic               tmr_done;
  logic               cfg_latch;

  function automatic logic [CNT_W-1:0] clamp_len(input logic [CNT_W-1:0] len);
    return CNT_W'(max1(32'(len)));
  endfunction

  sc_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (tmr_load),
    .value (tmr_value),
    .done  (tmr_done)
  );

  // Next-state, timer reload and frame-end decode. The phi1 length is consumed
  // straight into the timer at PHI1 entry, so only phi2/dead lengths are held.
  always_comb begin
    state_d   = state_q;
    tmr_load  = 1'b0;
    tmr_value = '0;
    cfg_latch = 1'b0;
    frame_cnt_d = frame_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.en) begin
          state_d   = ST_PHI1;
          cfg_latch = 1'b1;
          tmr_load  = 1'b1;
          tmr_value = clamp_len(bus.phi1_len) - CNT_W'(1);
        end
      end
      ST_PHI1: begin
        if (tmr_done) begin
          state_d   = ST_DEAD12;
          tmr_load  = 1'b1;
          tmr_value = nd_q - CNT_W'(1);
        end
      end
      ST_DEAD12: begin
        if (tmr_done) begin
          state_d   = ST_PHI2;
          tmr_load  = 1'b1;
          tmr_value = n2_q - CNT_W'(1);
        end
      end
      ST_PHI2: begin
        if (tmr_done) begin
          state_d   = ST_DEAD21;
          tmr_load  = 1'b1;
          tmr_value = nd_q - CNT_W'(1);
        end
      end
      ST_DEAD21: begin
        if (tmr_done) begin
          frame_cnt_d = frame_cnt_q + FRAME_W'(1);
          if (bus.en) begin
            state_d   = ST_PHI1;
            cfg_latch = 1'b1;
            tmr_load  = 1'b1;
            tmr_value = clamp_len(bus.phi1_len) - CNT_W'(1);
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Lengths for the rest of the frame are frozen when the frame starts.
  always_comb begin
    n2_d = n2_q;
    nd_d = nd_q;
    if (cfg_latch) begin
      n2_d = clamp_len(bus.phi2_len);
      nd_d = clamp_len(bus.dead_len);
    end
  end

  // State, latched lengths and frame counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      n2_q        <= CNT_W'(MIN_LEN);
      nd_q        <= CNT_W'(MIN_LEN);
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      n2_q        <= n2_d;
      nd_q        <= nd_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Phase gates come straight off flop bits so they cannot glitch.
  assign bus.phi1       = state_q[ST_PHI1_B];
  assign bus.phi2       = state_q[ST_PHI2_B];
  assign bus.busy       = ~state_q[ST_IDLE_B];
  assign bus.sample_stb = state_q[ST_PHI2_B] & tmr_done;
  assign bus.frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_sc_phase_gen.sv
module tb_sc_phase_gen;

  localparam int CNT_W   = 8;
  localparam int FRAME_W = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sc_phase_gen_if #(.CNT_W(CNT_W), .FRAME_W(FRAME_W)) bus ();

  sc_phase_gen #(.CNT_W(CNT_W), .FRAME_W(FRAME_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  // Reference model: each frame is expanded into a list of per-cycle slots
  // when it starts, then replayed one slot per clock.
  typedef struct packed {logic p1; logic p2; logic stb;} slot_t;
  slot_t              mq[$];
  slot_t              cur;
  logic               cur_busy;
  logic [FRAME_W-1:0] m_frames;
  int unsigned        mn1, mn2, mnd;

  function automatic int unsigned clamp1(input int unsigned v);
    return (v == 0) ? 1 : v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      cur      = '0;
      cur_busy = 1'b0;
      m_frames = '0;
    end else begin
      if (mq.size() == 0) begin
        if (cur_busy) m_frames = m_frames + 1'b1;
        if (bus.en) begin
          mn1 = clamp1(bus.phi1_len);
          mn2 = clamp1(bus.phi2_len);
          mnd = clamp1(bus.dead_len);
          for (int i = 0; i < mn1; i++) mq.push_back(3'b100);
          for (int i = 0; i < mnd; i++) mq.push_back(3'b000);
          for (int i = 0; i < mn2; i++) mq.push_back((i == mn2 - 1) ? 3'b011 : 3'b010);
          for (int i = 0; i < mnd; i++) mq.push_back(3'b000);
        end
      end
      if (mq.size() != 0) begin
        cur      = mq.pop_front();
        cur_busy = 1'b1;
      end else begin
        cur      = '0;
        cur_busy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("cycle{phi1,phi2,stb,busy,frame_cnt}",
        {24'd0, bus.phi1, bus.phi2, bus.sample_stb, bus.busy, bus.frame_cnt},
        {24'd0, cur.p1, cur.p2, cur.stb, cur_busy, m_frames});
  end

  always @(bus.phi1 or bus.phi2) begin
    assert (!(bus.phi1 && bus.phi2)) else $error("phi1 and phi2 high together");
  end

  task automatic do_reset();
    @(negedge clk);
    bus.en = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic set_len(input int a, input int b, input int d);
    bus.phi1_len = CNT_W'(a);
    bus.phi2_len = CNT_W'(b);
    bus.dead_len = CNT_W'(d);
  endtask

  task automatic wait_phi1(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus.phi1) ok = 1'b1;
    end
    if (!ok) chk("phi1_start_timeout", 32'd0, 32'd1);
  endtask

  // Called on the negedge where phi1 is first seen (index 0).
  task automatic measure_frame(output int p1w, output int p2w, output int gap,
                               output int stb, output int period);
    int p2_first;
    p1w = 0; p2w = 0; gap = -1; stb = -1; period = -1; p2_first = -1;
    for (int idx = 0; idx < 64 && period < 0; idx++) begin
      if (idx > 0) @(negedge clk);
      if (bus.phi1) begin
        if (p2_first >= 0) period = idx;
        else p1w++;
      end
      if (period < 0) begin
        if (bus.phi2) begin
          if (p2_first < 0) p2_first = idx;
          p2w++;
        end
        if (bus.sample_stb && stb < 0) stb = idx;
      end
    end
    gap = p2_first - p1w;
  endtask

  typedef struct {
    int n1, n2, nd;
    int p1w, p2w, gap, stb, period;
  } vec_t;

  vec_t tbl[6];

  initial begin
    bit ok;
    int p1w, p2w, gap, stb, period;
    int p1c, p2c, nstb;
    int stb_at[3];

    tbl[0] = '{4, 4, 2, 4, 4, 2, 9, 12};
    tbl[1] = '{0, 0, 0, 1, 1, 1, 2, 4};
    tbl[2] = '{5, 5, 2, 5, 5, 2, 11, 14};
    tbl[3] = '{1, 3, 1, 1, 3, 1, 4, 6};
    tbl[4] = '{6, 6, 1, 6, 6, 1, 12, 14};
    tbl[5] = '{2, 7, 0, 2, 7, 1, 9, 11};

    bus.en = 1'b0;
    set_len(0, 0, 0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_phi1", {31'd0, bus.phi1}, 32'd0);
    chk("rst_phi2", {31'd0, bus.phi2}, 32'd0);
    chk("rst_stb", {31'd0, bus.sample_stb}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_frame_cnt", {28'd0, bus.frame_cnt}, 32'd0);
    #1 rst_n = 1'b1;

    // Frame shape for a range of lengths, including zero clamping.
    foreach (tbl[k]) begin
      do_reset();
      set_len(tbl[k].n1, tbl[k].n2, tbl[k].nd);
      bus.en = 1'b1;
      wait_phi1(ok);
      if (ok) begin
        measure_frame(p1w, p2w, gap, stb, period);
        chk($sformatf("vec%0d_phi1_width", k), p1w, tbl[k].p1w);
        chk($sformatf("vec%0d_phi2_width", k), p2w, tbl[k].p2w);
        chk($sformatf("vec%0d_dead", k), gap, tbl[k].gap);
        chk($sformatf("vec%0d_stb_idx", k), stb, tbl[k].stb);
        chk($sformatf("vec%0d_period", k), period, tbl[k].period);
      end
    end

    // Three back-to-back frames: strobe positions and frame count.
    do_reset();
    set_len(4, 4, 2);
    bus.en = 1'b1;
    wait_phi1(ok);
    nstb = 0;
    for (int idx = 0; idx <= 36; idx++) begin
      if (idx > 0) @(negedge clk);
      if (bus.sample_stb) begin
        if (nstb < 3) stb_at[nstb] = idx;
        nstb++;
      end
      if (idx == 35) chk("basic_frame_cnt_before", {28'd0, bus.frame_cnt}, 32'd2);
      if (idx == 36) chk("basic_frame_cnt_after", {28'd0, bus.frame_cnt}, 32'd3);
    end
    chk("basic_stb_count", nstb, 3);
    chk("basic_stb0", stb_at[0], 9);
    chk("basic_stb1", stb_at[1], 21);
    chk("basic_stb2", stb_at[2], 33);

    // en dropped early in phi1: the frame still completes, then idle.
    do_reset();
    set_len(5, 5, 2);
    bus.en = 1'b1;
    wait_phi1(ok);
    p1c = 0; p2c = 0;
    for (int idx = 0; idx <= 16; idx++) begin
      if (idx > 0) @(negedge clk);
      if (idx == 1) bus.en = 1'b0;
      if (bus.phi1) p1c++;
      if (bus.phi2) p2c++;
      if (idx == 13) chk("stop_busy_last", {31'd0, bus.busy}, 32'd1);
      if (idx == 14) chk("stop_busy_low", {31'd0, bus.busy}, 32'd0);
      if (idx == 14) chk("stop_frame_cnt", {28'd0, bus.frame_cnt}, 32'd1);
      if (idx == 16) chk("stop_still_idle", {31'd0, bus.busy}, 32'd0);
    end
    chk("stop_phi1_cycles", p1c, 5);
    chk("stop_phi2_cycles", p2c, 5);

    // phi1_len changed during phi2 only affects the following frame.
    do_reset();
    set_len(6, 6, 1);
    bus.en = 1'b1;
    wait_phi1(ok);
    p1c = 0; p2c = 0;
    for (int idx = 0; idx <= 17; idx++) begin
      if (idx > 0) @(negedge clk);
      if (idx == 9) bus.phi1_len = CNT_W'(2);
      if (idx < 14 && bus.phi1) p1c++;
      if (idx < 14 && bus.phi2) p2c++;
      if (idx == 15) chk("cfg_next_phi1_on", {31'd0, bus.phi1}, 32'd1);
      if (idx == 16) chk("cfg_next_phi1_off", {31'd0, bus.phi1}, 32'd0);
    end
    chk("cfg_cur_phi1_cycles", p1c, 6);
    chk("cfg_cur_phi2_cycles", p2c, 6);

    // Asynchronous reset in the middle of phi2 of the second frame.
    do_reset();
    set_len(3, 3, 1);
    bus.en = 1'b1;
    wait_phi1(ok);
    repeat (13) @(negedge clk);
    chk("rstmid_phi2_before", {31'd0, bus.phi2}, 32'd1);
    chk("rstmid_frame_before", {28'd0, bus.frame_cnt}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_phi2", {31'd0, bus.phi2}, 32'd0);
    chk("rstmid_busy", {31'd0, bus.busy}, 32'd0);
    chk("rstmid_frame_cnt", {28'd0, bus.frame_cnt}, 32'd0);
    #1 rst_n = 1'b1;
    chk("rstmid_phi1_pre_edge", {31'd0, bus.phi1}, 32'd0);
    @(negedge clk);
    chk("rstmid_phi1_post_edge", {31'd0, bus.phi1}, 32'd1);

    // frame_cnt wraps after 2^FRAME_W frames.
    do_reset();
    set_len(0, 0, 0);
    bus.en = 1'b1;
    wait_phi1(ok);
    for (int idx = 1; idx <= 68; idx++) begin
      @(negedge clk);
      if (idx == 56) chk("wrap_14", {28'd0, bus.frame_cnt}, 32'd14);
      if (idx == 60) chk("wrap_15", {28'd0, bus.frame_cnt}, 32'd15);
      if (idx == 64) chk("wrap_0", {28'd0, bus.frame_cnt}, 32'd0);
      if (idx == 68) chk("wrap_1", {28'd0, bus.frame_cnt}, 32'd1);
    end

    // Random run; every cycle is compared against the frame model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 19) == 0) bus.en = ~bus.en;
      if ($urandom_range(0, 9) == 0)
        set_len(int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                int'($urandom_range(0, 3)));
      if ($urandom_range(0, 599) == 0) begin
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
